// File: rtl/uc_pkg.sv
// Shared encodings for the uc_seq control unit: opcode map, FSM states and
// the pending I/O access type latched while the PC is stalled.
package uc_pkg;

  localparam logic [2:0] OP_ALU_RR = 3'b000;
  localparam logic [2:0] OP_ALU_IM = 3'b001;

  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JZ   = 6'b010001;
  localparam logic [5:0] OP_JNZ  = 6'b010010;
  localparam logic [5:0] OP_NOP  = 6'b010011;
  localparam logic [5:0] OP_IN   = 6'b011000;
  localparam logic [5:0] OP_OUT  = 6'b011001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_EXEC    = 2'b00,
    S_IO_WAIT = 2'b01,
    S_HALT    = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'b00,
    PEND_IN   = 2'b01,
    PEND_OUT  = 2'b10
  } pend_t;

endpackage

// File: rtl/uc_io_timer.sv
// Clearable, enabled up-counter that flags the last cycle an I/O access may
// wait for its acknowledge.
module uc_io_timer #(
  parameter int CNT_W      = 5,
  parameter int IO_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(IO_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit for the single-cycle CPU datapath: opcode decode,
// PC stall on the I/O req/ack handshake, HALT/run, and sticky error flags.
module uc_seq
  import uc_pkg::*;
#(
  parameter int IO_TIMEOUT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       io_ack,
  input  logic       run,
  output logic       s_inc,
  output logic       s_inm,
  output logic       s_datos,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu,
  output logic       pc_en,
  output logic       io_rd,
  output logic       io_wr,
  output logic       halted,
  output logic       io_err,
  output logic       ill_op
);

  state_t state, state_nxt;
  pend_t  pend, pend_nxt;
  logic   resume, resume_nxt;
  logic   set_err, set_ill;
  logic   tmr_clr, tmr_en, tmr_exp;
  logic   we3_c, wez_c, pc_en_c, io_rd_c, io_wr_c;

  uc_io_timer #(
    .CNT_W      (CNT_W),
    .IO_TIMEOUT (IO_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_EXEC;
      pend   <= PEND_NONE;
      resume <= 1'b0;
      io_err <= 1'b0;
      ill_op <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      resume <= resume_nxt;
      if (set_err) io_err <= 1'b1;
      if (set_ill) ill_op <= 1'b1;
    end
  end

  always_comb begin
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    s_datos    = 1'b0;
    we3_c      = 1'b0;
    wez_c      = 1'b0;
    op_alu     = 3'b000;
    pc_en_c    = 1'b1;
    io_rd_c    = 1'b0;
    io_wr_c    = 1'b0;
    state_nxt  = state;
    pend_nxt   = pend;
    resume_nxt = 1'b0;
    set_err    = 1'b0;
    set_ill    = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    case (state)
      S_EXEC: begin
        // The cycle after run still fetches the HALT word; step over it.
        if (!resume) begin
          if (opcode[5:3] == OP_ALU_RR || opcode[5:3] == OP_ALU_IM) begin
            op_alu = opcode[2:0];
            s_inm  = (opcode[5:3] == OP_ALU_IM);
            we3_c  = 1'b1;
            wez_c  = 1'b1;
          end else begin
            case (opcode)
              OP_J:   s_inc = 1'b0;
              OP_JZ:  s_inc = ~z;
              OP_JNZ: s_inc = z;
              OP_NOP: ;
              OP_IN, OP_OUT: begin
                s_datos = (opcode == OP_IN);
                io_rd_c = (opcode == OP_IN);
                io_wr_c = (opcode == OP_OUT);
                if (io_ack) begin
                  we3_c = (opcode == OP_IN);
                end else begin
                  pc_en_c   = 1'b0;
                  tmr_clr   = 1'b1;
                  state_nxt = S_IO_WAIT;
                  pend_nxt  = (opcode == OP_IN) ? PEND_IN : PEND_OUT;
                end
              end
              OP_HALT: begin
                pc_en_c   = 1'b0;
                state_nxt = S_HALT;
              end
              default: set_ill = 1'b1;
            endcase
          end
        end
      end

      S_IO_WAIT: begin
        s_datos = (pend == PEND_IN);
        io_rd_c = (pend == PEND_IN);
        io_wr_c = (pend == PEND_OUT);
        pc_en_c = 1'b0;
        tmr_en  = 1'b1;
        // Ack takes priority over expiry on the same cycle.
        if (io_ack) begin
          pc_en_c   = 1'b1;
          we3_c     = (pend == PEND_IN);
          state_nxt = S_EXEC;
          pend_nxt  = PEND_NONE;
        end else if (tmr_exp) begin
          pc_en_c   = 1'b1;
          set_err   = 1'b1;
          state_nxt = S_EXEC;
          pend_nxt  = PEND_NONE;
        end
      end

      S_HALT: begin
        pc_en_c = 1'b0;
        if (run) begin
          resume_nxt = 1'b1;
          state_nxt  = S_EXEC;
        end
      end

      default: state_nxt = S_EXEC;
    endcase
  end

  assign we3    = reset & we3_c;
  assign wez    = reset & wez_c;
  assign pc_en  = reset & pc_en_c;
  assign io_rd  = reset & io_rd_c;
  assign io_wr  = reset & io_wr_c;
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed scenarios with literal expectations
// followed by randomized traffic checked against a cycle-level reference model.
module tb_uc_seq;

  localparam int IO_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'b010011;
  logic       z = 1'b0;
  logic       io_ack = 1'b0;
  logic       run = 1'b0;
  logic       s_inc, s_inm, s_datos, we3, wez, pc_en, io_rd, io_wr;
  logic       halted, io_err, ill_op;
  logic [2:0] op_alu;

  int n_chk = 0;
  int n_pass = 0;

  uc_seq #(.IO_TIMEOUT(IO_TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .io_ack(io_ack), .run(run),
    .s_inc(s_inc), .s_inm(s_inm), .s_datos(s_datos), .we3(we3), .wez(wez),
    .op_alu(op_alu), .pc_en(pc_en), .io_rd(io_rd), .io_wr(io_wr),
    .halted(halted), .io_err(io_err), .ill_op(ill_op)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  // Inputs change just after the rising edge; results are read at the falling edge.
  task automatic step(input logic [5:0] op, input logic zz, input logic ack,
                      input logic rr, input logic rs);
    @(posedge clk);
    #1;
    opcode = op; z = zz; io_ack = ack; run = rr; reset = rs;
    @(negedge clk);
  endtask

  // Reference model: how many cycles an access has waited (-1 = none),
  // whether the machine is parked, and whether it is stepping past HALT.
  int   m_wait = -1;
  logic m_in = 1'b0, m_halt = 1'b0, m_resume = 1'b0, m_err = 1'b0, m_ill = 1'b0;

  always @(negedge clk) begin
    logic e_sinc, e_sinm, e_sdat, e_we3, e_wez, e_pc, e_rd, e_wr, e_err, e_ill, e_halt;
    logic [2:0] e_op;
    int o;
    if (!reset) begin
      m_wait = -1; m_in = 1'b0; m_halt = 1'b0; m_resume = 1'b0; m_err = 1'b0; m_ill = 1'b0;
      chk1("rst_we3", we3, 1'b0);
      chk1("rst_wez", wez, 1'b0);
      chk1("rst_pc_en", pc_en, 1'b0);
      chk1("rst_io_rd", io_rd, 1'b0);
      chk1("rst_io_wr", io_wr, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk1("rst_io_err", io_err, 1'b0);
      chk1("rst_ill_op", ill_op, 1'b0);
    end else begin
      e_sinc = 1'b1; e_sinm = 1'b0; e_sdat = 1'b0; e_we3 = 1'b0; e_wez = 1'b0;
      e_op = 3'b000; e_pc = 1'b1; e_rd = 1'b0; e_wr = 1'b0;
      e_err = m_err; e_ill = m_ill; e_halt = m_halt;
      o = int'(opcode);
      if (m_halt) begin
        e_pc = 1'b0;
        if (run) begin m_halt = 1'b0; m_resume = 1'b1; end
      end else if (m_wait >= 0) begin
        e_sdat = m_in; e_rd = m_in; e_wr = !m_in; e_pc = 1'b0;
        if (io_ack) begin
          e_pc = 1'b1; e_we3 = m_in; m_wait = -1;
        end else if (m_wait == IO_TIMEOUT - 1) begin
          e_pc = 1'b1; m_err = 1'b1; m_wait = -1;
        end else begin
          m_wait++;
        end
      end else if (m_resume) begin
        m_resume = 1'b0;
      end else if (o < 16) begin
        e_op = opcode[2:0]; e_we3 = 1'b1; e_wez = 1'b1; e_sinm = (o >= 8);
      end else if (o == 16) e_sinc = 1'b0;
      else if (o == 17) e_sinc = !z;
      else if (o == 18) e_sinc = z;
      else if (o == 19) ;
      else if (o == 24 || o == 25) begin
        e_sdat = (o == 24); e_rd = (o == 24); e_wr = (o == 25);
        if (io_ack) e_we3 = (o == 24);
        else begin e_pc = 1'b0; m_wait = 0; m_in = (o == 24); end
      end else if (o == 63) begin
        e_pc = 1'b0; m_halt = 1'b1;
      end else m_ill = 1'b1;

      chk1("s_inc", s_inc, e_sinc);
      chk1("s_inm", s_inm, e_sinm);
      chk1("s_datos", s_datos, e_sdat);
      chk1("we3", we3, e_we3);
      chk1("wez", wez, e_wez);
      chk3("op_alu", op_alu, e_op);
      chk1("pc_en", pc_en, e_pc);
      chk1("io_rd", io_rd, e_rd);
      chk1("io_wr", io_wr, e_wr);
      chk1("halted", halted, e_halt);
      chk1("io_err", io_err, e_err);
      chk1("ill_op", ill_op, e_ill);
    end
  end

  initial begin
    int ack_pct;
    logic [5:0] op;
    logic [5:0] legal [12];
    legal = '{6'b000010, 6'b000111, 6'b001011, 6'b001100, 6'b010000, 6'b010001,
              6'b010010, 6'b010011, 6'b011000, 6'b011001, 6'b011000, 6'b011001};

    repeat (3) @(negedge clk);
    chk1("lit_rst_pc_en", pc_en, 1'b0);
    chk1("lit_rst_io_err", io_err, 1'b0);

    step(6'b000010, 0, 0, 0, 1);
    chk3("lit_alu_op", op_alu, 3'b010);
    chk1("lit_alu_we3", we3, 1'b1);
    chk1("lit_alu_wez", wez, 1'b1);
    chk1("lit_alu_pc_en", pc_en, 1'b1);
    chk1("lit_alu_s_inc", s_inc, 1'b1);
    chk1("lit_alu_s_inm", s_inm, 1'b0);

    step(6'b010001, 1, 0, 0, 1);
    chk1("lit_jz1_s_inc", s_inc, 1'b0);
    chk1("lit_jz1_we3", we3, 1'b0);
    chk1("lit_jz1_wez", wez, 1'b0);
    step(6'b010001, 0, 0, 0, 1);
    chk1("lit_jz0_s_inc", s_inc, 1'b1);
    chk1("lit_jz0_wez", wez, 1'b0);

    for (int i = 0; i < 3; i++) begin
      step(6'b011000, 0, 0, 0, 1);
      chk1("lit_in_wait_pc_en", pc_en, 1'b0);
      chk1("lit_in_wait_we3", we3, 1'b0);
      chk1("lit_in_wait_io_rd", io_rd, 1'b1);
      chk1("lit_in_wait_s_datos", s_datos, 1'b1);
    end
    step(6'b011000, 0, 1, 0, 1);
    chk1("lit_in_ack_we3", we3, 1'b1);
    chk1("lit_in_ack_pc_en", pc_en, 1'b1);
    step(6'b010011, 0, 0, 0, 1);
    chk1("lit_in_done_io_err", io_err, 1'b0);
    chk1("lit_in_done_io_rd", io_rd, 1'b0);

    step(6'b011001, 0, 0, 0, 1);
    for (int i = 1; i < IO_TIMEOUT; i++) begin
      step(6'b011001, 0, 0, 0, 1);
      chk1("lit_ackexp_pc_en_low", pc_en, 1'b0);
    end
    step(6'b011001, 0, 1, 0, 1);
    chk1("lit_ackexp_pc_en", pc_en, 1'b1);
    step(6'b010011, 0, 0, 0, 1);
    chk1("lit_ackexp_io_err", io_err, 1'b0);

    step(6'b011001, 0, 0, 0, 1);
    chk1("lit_to_entry_io_wr", io_wr, 1'b1);
    for (int i = 1; i < IO_TIMEOUT; i++) begin
      step(6'b011001, 0, 0, 0, 1);
      chk1("lit_to_pc_en_low", pc_en, 1'b0);
    end
    step(6'b011001, 0, 0, 0, 1);
    chk1("lit_to_pc_en", pc_en, 1'b1);
    chk1("lit_to_we3", we3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(6'b010011, 0, 0, 0, 1);
      chk1("lit_to_io_err", io_err, 1'b1);
    end

    step(6'b111111, 0, 0, 0, 1);
    chk1("lit_halt_entry_pc_en", pc_en, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(6'b111111, 0, 0, 0, 1);
      chk1("lit_halt_halted", halted, 1'b1);
      chk1("lit_halt_pc_en", pc_en, 1'b0);
    end
    step(6'b111111, 0, 0, 1, 1);
    chk1("lit_run_cycle_pc_en", pc_en, 1'b0);
    step(6'b111111, 0, 0, 0, 1);
    chk1("lit_resume_pc_en", pc_en, 1'b1);
    chk1("lit_resume_halted", halted, 1'b0);
    chk1("lit_resume_s_inc", s_inc, 1'b1);
    step(6'b010011, 0, 0, 0, 1);
    chk1("lit_after_resume_halted", halted, 1'b0);

    step(6'b100101, 0, 0, 0, 1);
    chk1("lit_ill_we3", we3, 1'b0);
    chk1("lit_ill_wez", wez, 1'b0);
    chk1("lit_ill_io_wr", io_wr, 1'b0);
    step(6'b010011, 0, 0, 0, 1);
    chk1("lit_ill_flag", ill_op, 1'b1);

    step(6'b011000, 0, 0, 0, 1);
    step(6'b011000, 0, 0, 0, 1);
    step(6'b011000, 0, 0, 0, 0);
    chk1("lit_rstwait_we3", we3, 1'b0);
    chk1("lit_rstwait_pc_en", pc_en, 1'b0);
    chk1("lit_rstwait_io_rd", io_rd, 1'b0);
    step(6'b010011, 0, 0, 0, 1);
    chk1("lit_rstwait_io_err", io_err, 1'b0);
    chk1("lit_rstwait_ill_op", ill_op, 1'b0);
    chk1("lit_rstwait_pc_en_after", pc_en, 1'b1);
    chk1("lit_rstwait_io_rd_after", io_rd, 1'b0);

    ack_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ack_pct = (c / 200) % 3 == 0 ? 4 : ((c / 200) % 3 == 1 ? 30 : 75);
      case ($urandom_range(0, 19))
        0:       op = 6'b111111;
        1:       op = 6'($urandom_range(32, 62));
        default: op = legal[$urandom_range(0, 11)];
      endcase
      step(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < ack_pct),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) != 0));
    end
    step(6'b010011, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
